// File: rtl/ascon_core.sv
// rtl/ascon_core.sv - AXI4-Lite mapped ASCON permutation engine running one round per clock.
// Software loads x0..x4, writes START with a round count, and polls DONE or waits for irq.
module ascon_core #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 7,
  parameter bit C_IRQ_ACTIVE_STATE   = 1'b1
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              irq
);

  localparam int WW = C_S00_AXI_ADDR_WIDTH - 2;

  logic            aw_held_q, aw_held_d;
  logic [WW-1:0]   aw_word_q, aw_word_d;
  logic            w_held_q, w_held_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            bvalid_q, bvalid_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            irq_en_q, irq_en_d;
  logic [3:0]      nrounds_q, nrounds_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3:0]      round_q, round_d;
  logic [4:0][63:0] x_q, x_d;

  logic            wr_en;
  logic [31:0]     wmask;
  logic [31:0]     wr_old;
  logic [31:0]     wr_val;
  logic [WW-1:0]   wr_sel;
  logic            start_req;
  logic            done_clr;
  logic [3:0]      n_eff;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s, input logic [3:0] r);
    logic [4:0][63:0] x;
    logic [4:0][63:0] t;
    x = s;
    x[2][7:0] = x[2][7:0] ^ (8'hF0 - 8'(r) * 8'h0F);
    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
    for (int i = 0; i < 5; i++) x[i] = x[i] ^ t[(i + 1) % 5];
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];
    x[0] = x[0] ^ ror64(x[0], 19) ^ ror64(x[0], 28);
    x[1] = x[1] ^ ror64(x[1], 61) ^ ror64(x[1], 39);
    x[2] = x[2] ^ ror64(x[2], 1)  ^ ror64(x[2], 6);
    x[3] = x[3] ^ ror64(x[3], 10) ^ ror64(x[3], 17);
    x[4] = x[4] ^ ror64(x[4], 7)  ^ ror64(x[4], 41);
    return x;
  endfunction

  // Word 2..11 maps to x[(w-2)/2], low half on even offsets.
  function automatic logic [31:0] reg_read(input logic [WW-1:0] w, input logic ien,
                                           input logic [3:0] nr, input logic bsy,
                                           input logic dn, input logic [4:0][63:0] x);
    logic [WW-1:0] sel;
    logic [31:0]   v;
    v   = '0;
    sel = w - WW'(2);
    if (w == WW'(0))       v = {20'd0, nr, 6'd0, ien, 1'b0};
    else if (w == WW'(1))  v = {30'd0, dn, bsy};
    else if (w <= WW'(11)) v = sel[0] ? x[3'(sel >> 1)][63:32] : x[3'(sel >> 1)][31:0];
    return v;
  endfunction

  always_comb begin
    aw_held_d = aw_held_q;
    aw_word_d = aw_word_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    irq_en_d  = irq_en_q;
    nrounds_d = nrounds_q;
    busy_d    = busy_q;
    done_d    = done_q;
    round_d   = round_q;
    x_d       = x_q;
    start_req = 1'b0;
    done_clr  = 1'b0;

    wr_en  = aw_held_q && w_held_q && !bvalid_q;
    wmask  = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    wr_old = reg_read(aw_word_q, irq_en_q, nrounds_q, busy_q, done_q, x_q);
    wr_val = (wr_old & ~wmask) | (wdata_q & wmask);
    wr_sel = aw_word_q - WW'(2);

    if (awready_q && s00_axi_awvalid) begin
      aw_held_d = 1'b1;
      aw_word_d = s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
    end
    if (wready_q && s00_axi_wvalid) begin
      w_held_d = 1'b1;
      wdata_d  = s00_axi_wdata;
      wstrb_d  = s00_axi_wstrb;
    end

    if (wr_en) begin
      bvalid_d = 1'b1;
      if (aw_word_q == WW'(0)) begin
        irq_en_d  = wr_val[1];
        nrounds_d = wr_val[11:8];
        start_req = wstrb_q[0] & wdata_q[0];
      end else if (aw_word_q == WW'(1)) begin
        done_clr = wstrb_q[0] & wdata_q[1];
      end else if (aw_word_q <= WW'(11) && !busy_q) begin
        if (wr_sel[0]) x_d[3'(wr_sel >> 1)][63:32] = wr_val;
        else           x_d[3'(wr_sel >> 1)][31:0]  = wr_val;
      end
    end
    if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;

    if (arready_q && s00_axi_arvalid) begin
      rvalid_d = 1'b1;
      rdata_d  = reg_read(s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2], irq_en_q, nrounds_q,
                          busy_q, done_q, x_q);
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
    arready_d = !rvalid_d;

    // The round count comes from the same CTRL write that carries START.
    n_eff = (nrounds_d == 4'd0 || nrounds_d > 4'd12) ? 4'd12 : nrounds_d;
    if (done_clr) done_d = 1'b0;
    if (start_req && !busy_q) begin
      busy_d  = 1'b1;
      done_d  = 1'b0;
      round_d = 4'd12 - n_eff;
    end
    // Completion is evaluated last so a same-cycle DONE clear loses.
    if (busy_q) begin
      x_d     = ascon_round(x_q, round_q);
      round_d = round_q + 4'd1;
      if (round_q == 4'd11) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      aw_held_q <= 1'b0;
      aw_word_q <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      irq_en_q  <= 1'b0;
      nrounds_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      round_q   <= '0;
      x_q       <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_word_q <= aw_word_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      irq_en_q  <= irq_en_d;
      nrounds_q <= nrounds_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      round_q   <= round_d;
      x_q       <= x_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign irq = C_IRQ_ACTIVE_STATE ? (done_q & irq_en_q) : ~(done_q & irq_en_q);

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_ascon_core.sv
// tb/tb_ascon_core.sv - randomized self-checking bench for ascon_core.
// Expected permutation results come from a loop-based behavioural model of the round rules.
`timescale 1ns/1ps
module tb_ascon_core;

  logic        clk = 1'b0;
  logic        resetn;
  logic [6:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [63:0] m [5];
  logic [31:0] rd, old_w, new_w, msk;
  logic [3:0]  st;
  int          wi, nr, neff, lat;

  localparam int ROT_A[5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B[5] = '{28, 39, 6, 17, 41};

  always #5 clk = ~clk;

  ascon_core dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(resetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .irq(irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  task automatic model_perm(input int rounds);
    logic [63:0] t [5];
    int n;
    n = (rounds == 0 || rounds > 12) ? 12 : rounds;
    for (int r = 12 - n; r < 12; r++) begin
      m[2] = m[2] ^ 64'(240 - 15 * r);
      m[0] = m[0] ^ m[4];
      m[4] = m[4] ^ m[3];
      m[2] = m[2] ^ m[1];
      for (int i = 0; i < 5; i++) t[i] = ~m[i] & m[(i + 1) % 5];
      for (int i = 0; i < 5; i++) m[i] = m[i] ^ t[(i + 1) % 5];
      m[1] = m[1] ^ m[0];
      m[0] = m[0] ^ m[4];
      m[3] = m[3] ^ m[2];
      m[2] = ~m[2];
      for (int i = 0; i < 5; i++) m[i] = m[i] ^ rotr(m[i], ROT_A[i]) ^ rotr(m[i], ROT_B[i]);
    end
  endtask

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_delay);
    bit aw_ok = 0;
    bit w_ok = 0;
    int t = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_ok && w_ok) && t < 40) begin
      awvalid = !aw_ok;
      wvalid  = !w_ok && (t >= w_delay);
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      @(negedge clk);
      t++;
    end
    awvalid = 0; wvalid = 0;
    chk("aw_w_accepted", {62'd0, aw_ok, w_ok}, 64'd3);
    t = 0;
    while (!bvalid && t < 20) begin @(negedge clk); t++; end
    chk("bvalid_seen", bvalid, 1);
    chk("bresp_okay", bresp, 0);
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk("bvalid_single", bvalid, 0);
  endtask

  task automatic axi_read(input logic [6:0] a, output logic [31:0] d);
    int t = 0;
    araddr = a; arvalid = 1;
    while (!arready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    arvalid = 0;
    t = 0;
    while (!rvalid && t < 20) begin @(negedge clk); t++; end
    chk("rvalid_seen", rvalid, 1);
    chk("rresp_okay", rresp, 0);
    d = rdata;
    rready = 1;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic write_state();
    for (int i = 0; i < 5; i++) begin
      axi_write(7'(8 + 8 * i), m[i][31:0], 4'hF, 0);
      axi_write(7'(12 + 8 * i), m[i][63:32], 4'hF, 0);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 5; i++) begin
      axi_read(7'(8 + 8 * i), v);
      chk($sformatf("%s_x%0d_lo", tag, i), v, m[i][31:0]);
      axi_read(7'(12 + 8 * i), v);
      chk($sformatf("%s_x%0d_hi", tag, i), v, m[i][63:32]);
    end
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    int t = 0;
    axi_read(7'h04, v);
    while (v[0] && t < 40) begin axi_read(7'h04, v); t++; end
    chk("run_finishes", v[0], 0);
  endtask

  task automatic measure_latency(input int expect_n);
    int j = 1;
    while (irq !== 1'b1 && j < 40) begin @(negedge clk); j++; end
    chk("latency", j, expect_n);
  endtask

  initial begin
    resetn = 0; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    resetn = 1;
    @(negedge clk);

    axi_read(7'h00, rd); chk("rst_ctrl", rd, 0);
    axi_read(7'h04, rd); chk("rst_status", rd, 0);
    axi_read(7'h08, rd); chk("rst_x0lo", rd, 0);
    chk("rst_irq", irq, 0);

    axi_write(7'h08, 32'h12345678, 4'hF, 2);
    axi_read(7'h08, rd); chk("wr_full", rd, 32'h12345678);
    axi_write(7'h08, 32'hFFFFFFFF, 4'h3, 0);
    axi_read(7'h08, rd); chk("wr_strb3", rd, 32'h1234FFFF);
    axi_write(7'h7C, 32'hDEADBEEF, 4'hF, 1);
    axi_read(7'h7C, rd); chk("unmapped_reads_zero", rd, 0);

    // Back-pressure: response held, second address must not be taken.
    awaddr = 7'h0C; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awaddr = 7'h10; wvalid = 0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("hold_bvalid", bvalid, 1);
      chk("hold_awready", awready, 0);
      @(negedge clk);
    end
    bready = 1; awvalid = 0;
    @(negedge clk);
    bready = 0;
    araddr = 7'h0C; arvalid = 1;
    @(negedge clk);
    araddr = 7'h08;
    for (int k = 0; k < 5; k++) begin
      chk("hold_rvalid", rvalid, 1);
      chk("hold_rdata", rdata, 32'hCAFEF00D);
      chk("hold_arready", arready, 0);
      @(negedge clk);
    end
    rready = 1; arvalid = 0;
    @(negedge clk);
    rready = 0;
    axi_read(7'h10, rd); chk("second_aw_ignored", rd, 0);

    m[0] = 64'h80400C0600000000; m[1] = 0; m[2] = 0; m[3] = 0; m[4] = 0;
    write_state();
    axi_write(7'h00, 32'h00000C03, 4'hF, 0);
    measure_latency(12);
    model_perm(12);
    axi_read(7'h04, rd); chk("p12_status", rd, 32'h2);
    chk("p12_irq", irq, 1);
    check_state("p12");

    for (int i = 0; i < 5; i++) m[i] = {$urandom, $urandom};
    write_state();
    axi_write(7'h00, 32'h00000603, 4'hF, 0);
    measure_latency(6);
    model_perm(6);
    axi_read(7'h00, rd); chk("ctrl_readback", rd, 32'h602);
    check_state("p6");

    for (int i = 0; i < 5; i++) m[i] = {$urandom, $urandom};
    write_state();
    axi_write(7'h00, 32'h00000003, 4'hF, 0);
    axi_write(7'h08, $urandom, 4'hF, 0);
    axi_write(7'h00, 32'h00000003, 4'hF, 0);
    model_perm(0);
    wait_idle();
    axi_read(7'h04, rd); chk("p0_status", rd, 32'h2);
    check_state("p0");

    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 5; i++) m[i] = {$urandom, $urandom};
      write_state();
      wi = $urandom_range(0, 9);
      st = 4'($urandom_range(1, 15));
      new_w = $urandom;
      msk = 0;
      for (int b = 0; b < 4; b++) if (st[b]) msk[8 * b +: 8] = 8'hFF;
      old_w = wi[0] ? m[wi / 2][63:32] : m[wi / 2][31:0];
      old_w = (old_w & ~msk) | (new_w & msk);
      if (wi[0]) m[wi / 2][63:32] = old_w; else m[wi / 2][31:0] = old_w;
      axi_write(7'(8 + 4 * wi), new_w, st, $urandom_range(0, 3));
      nr = $urandom_range(0, 15);
      neff = (nr == 0 || nr > 12) ? 12 : nr;
      axi_write(7'h00, {20'd0, 4'(nr), 8'h03}, 4'hF, 0);
      measure_latency(neff);
      model_perm(nr);
      check_state($sformatf("rand%0d", it));
    end

    axi_write(7'h04, 32'h2, 4'hF, 0);
    axi_read(7'h04, rd); chk("done_w1c", rd, 0);
    chk("irq_cleared", irq, 0);

    axi_write(7'h00, 32'h00000C01, 4'hF, 0);
    repeat (3) @(negedge clk);
    resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    axi_read(7'h04, rd); chk("abort_status", rd, 0);
    axi_read(7'h00, rd); chk("abort_ctrl", rd, 0);
    for (int i = 0; i < 5; i++) m[i] = 0;
    check_state("abort");
    chk("abort_irq", irq, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
